// File: rtl/intm_cdb_arbiter_if.sv
// Bundle between the mul/div result producers, the arbiter and the CDB.
// The producer/CDB side uses "master", the arbiter uses "slave".
interface intm_cdb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [IDX_W-1:0]          out_src;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/intm_cdb_arbiter.sv
// Round-robin arbiter sharing the integer mul/div CDB write port among
// NUM_REQ long-latency producers, with a one-entry valid/ready output stage
// so the CDB can apply backpressure without losing results.
module intm_cdb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,       // asynchronous, active low
    input  logic               flush,
    intm_cdb_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0]  out_src_q,   out_src_d;
    logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic               load;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  grant_data;
    logic [IDX_W-1:0]   sel;
    int                 idx_int;

    // The output stage can take a new result when empty or being drained,
    // unless a flush is discarding it this cycle.
    assign load = (~out_valid_q | bus.out_ready) & ~flush;

    // Round-robin search starting at rr_ptr; first requester wins.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        found      = 1'b0;
        sel        = '0;
        idx_int    = 0;
        if (load) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_int = int'(rr_ptr_q) + k;
                if (idx_int >= NUM_REQ) begin
                    idx_int = idx_int - NUM_REQ;
                end
                sel = IDX_W'(idx_int);
                if (!found && bus.req_valid[sel]) begin
                    found      = 1'b1;
                    grant[sel] = 1'b1;
                    grant_idx  = sel;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Producers see their grant directly; forced low while reset is held.
    assign bus.req_ready = grant & {NUM_REQ{rst}};

    // Next-state for the output stage, round-robin pointer and stall counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_src_d   = grant_idx;
                rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // Someone is waiting and nobody won: count it, saturating at all-ones.
        if ((|bus.req_valid) && !found && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of every other flop, independent of statement order.
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign stall_cnt     = stall_cnt_q;

endmodule
